// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// instruction-type encodings and the fetch state encoding.
package fetch_unit_pkg;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;
    localparam int OP_MSB   = 29;
    localparam int OP_LSB   = 26;
    localparam int RD_MSB   = 25;
    localparam int RD_LSB   = 21;
    localparam int RS1_MSB  = 20;
    localparam int RS1_LSB  = 16;
    localparam int RS2_MSB  = 15;
    localparam int RS2_LSB  = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        R_TYPE = 2'b00,
        I_TYPE = 2'b01,
        M_TYPE = 2'b10,
        B_TYPE = 2'b11
    } instr_type_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular instruction queue with count-based full/empty, flush, and
// push-while-full allowed when a pop happens in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, RUN/HALT control, redirect with epoch filtering and a
// credit-limited issue into fetch_queue. Define FETCH_PERF_EN for perf counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          INSTR_W  = 32,
    parameter int          DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [1:0]        id_type,
    output logic [3:0]        id_op,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_rs1,
    output logic [4:0]        id_rs2,
    output logic [15:0]       id_imm
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int QW    = ADDR_W + INSTR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_epoch;
    logic              epoch;
    logic              pop;
    logic              issue;
    logic              push;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              q_full;
    logic [QW-1:0]     q_head;
    logic [INSTR_W-1:0] head_instr;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W:0]    credit_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (halt)  state_nxt = ST_HALT;
            ST_HALT: if (!halt) state_nxt = ST_RUN;
        endcase
    end

    // Credit check counts queued entries plus the outstanding read, net of this cycle's pop.
    assign pop          = id_valid & id_ready;
    assign credit_used  = {1'b0, q_count} + (CNT_W+1)'(inflight);
    assign credit_limit = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop);
    assign issue        = rst_n & (state == ST_RUN) & ~halt & ~redirect_valid
                        & (credit_used < credit_limit);
    assign imem_en      = issue;
    assign imem_addr    = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= pc;
                inflight_epoch <= epoch;
            end
            if (redirect_valid) begin
                pc    <= redirect_pc;
                epoch <= ~epoch;
            end else if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    // A same-cycle redirect flushes the queue, which also discards this push.
    assign push = inflight & (inflight_epoch == epoch);

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    push_never_dropped: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && q_full && !pop && !redirect_valid));

    assign id_valid   = ~q_empty;
    assign head_instr = q_empty ? '0 : q_head[INSTR_W-1:0];
    assign id_pc      = q_empty ? '0 : q_head[QW-1:INSTR_W];
    assign id_type    = head_instr[TYPE_MSB:TYPE_LSB];
    assign id_op      = head_instr[OP_MSB:OP_LSB];
    assign id_rd      = head_instr[RD_MSB:RD_LSB];
    assign id_rs1     = head_instr[RS1_MSB:RS1_LSB];
    assign id_rs2     = head_instr[RS2_MSB:RS2_LSB];
    assign id_imm     = head_instr[IMM_MSB:IMM_LSB];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid)        perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (id_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
